alu_resp_tx: RTL and testbench
==============================

# alu_resp_tx

Response serializer sitting directly downstream of the ALU and the register-file read port, upstream of the UART TX FIFO. It captures one registered result, either a multi-byte ALU result or a single register-file read byte, and emits it as a sequence of bytes, LSB first, over a valid/ready handshake. It raises `BUSY` for the duration so the system controller withholds the next ALU enable or register read. It also reports dropped results and counts completed responses.

## Interface
Parameters:
- `OUT_WIDTH`, 16, ALU result width. Must be a multiple of 8, range 8–64. `NUM_BYTES = OUT_WIDTH/8`.
- `DATA_WIDTH`, 8, register-file read data and TX byte width. Fixed at 8.

Ports:
- `CLK`  in  1  single clock; the only clock in the block.
- `RST`  in  1  reset; asynchronous, active-high.
- `ALU_OUT`  in  OUT_WIDTH  registered ALU result.
- `OUT_VALID`  in  1  one-cycle strobe; `ALU_OUT` is valid.
- `RF_RD_DATA`  in  8  register-file read data.
- `RF_RD_VALID`  in  1  one-cycle strobe; `RF_RD_DATA` is valid.
- `TX_DATA`  out  8  byte to FIFO.
- `TX_VALID`  out  1  `TX_DATA` is valid.
- `TX_READY`  in  1  FIFO can accept; a transfer occurs on a rising edge with `TX_VALID & TX_READY`.
- `BUSY`  out  1  high whenever state is not IDLE.
- `OVERRUN`  out  1  sticky; set when a strobe is dropped.
- `OVR_CLR`  in  1  synchronous clear of `OVERRUN`.
- `RESP_CNT`  out  8  count of completed responses; wraps 255 → 0.

## Operation
- Two-state FSM: IDLE and SEND. Internal state:
  - `shreg[OUT_WIDTH-1:0]`, capture register.
  - `bytes_left`, width `clog2(NUM_BYTES+1)`.
- IDLE with `OUT_VALID=1`:
  - `shreg <= ALU_OUT`, `bytes_left <= NUM_BYTES`, go to SEND.
  - If `RF_RD_VALID=1` in the same cycle, the RF byte is dropped and `OVERRUN` is set.
- IDLE with only `RF_RD_VALID=1`: `shreg <= {0, RF_RD_DATA}`, `bytes_left <= 1`, go to SEND.
- SEND:
  - `TX_DATA = shreg[7:0]`, `TX_VALID = 1`.
  - On each transfer: `shreg <= shreg >> 8`, `bytes_left` decrements.
  - On the transfer where `bytes_left == 1`: go to IDLE and increment `RESP_CNT`.
- `TX_DATA` and `TX_VALID` are driven from registers/state only, never combinationally from `TX_READY`.
- Any `OUT_VALID` or `RF_RD_VALID` strobe while in SEND, including the final-transfer cycle, is dropped and sets `OVERRUN`. No queuing.
- `OVERRUN`:
  - Stays set until `OVR_CLR=1` clears it at the edge.
  - If a set event and `OVR_CLR` coincide, set wins.
- `TX_READY` low holds the current byte stable. There is no timeout.

## Timing
- Reset (`RST=1`, asynchronous): state IDLE, `TX_DATA=0`, `TX_VALID=0`, `BUSY=0`, `OVERRUN=0`, `RESP_CNT=0`, `shreg=0`.
- Reset mid-SEND aborts the frame immediately. No partial response is counted.
- Latency:
  - Strobe sampled at edge N; `TX_VALID` and `BUSY` are high after edge N, with byte 0 presented in cycle N+1.
  - With `TX_READY` held high, an ALU response takes `NUM_BYTES` consecutive cycles with back-to-back transfers. `TX_VALID` has no gaps.
  - After the last transfer edge, `BUSY=0` and `TX_VALID=0` in the next cycle. The earliest new capture is at the following edge.
- `RESP_CNT` updates at the same edge as the last byte's transfer.

## Test plan
- Reset, then `ALU_OUT=16'hA55A` with `OUT_VALID` pulse and `TX_READY=1` → bytes 0x5A, 0xA5 on consecutive cycles; `BUSY` high for 2 cycles; `RESP_CNT=1`; `OVERRUN=0`.
- `RF_RD_DATA=8'h3C` strobe with `TX_READY` low for 5 cycles, then high → `TX_DATA=0x3C` held stable, `TX_VALID=1` for 6 cycles; one transfer; `RESP_CNT` +1.
- `OUT_VALID` and `RF_RD_VALID` in the same cycle (`ALU_OUT=0x1234`, RF=0x77) → only 0x34, 0x12 sent; `OVERRUN=1`.
- Second `OUT_VALID` during SEND and during the final-transfer cycle → each dropped; `OVERRUN=1`. Pulse `OVR_CLR` → `OVERRUN=0`. Assert set and clear together → `OVERRUN` stays 1.
- `RST` pulsed after byte 0 of 0xBEEF is transferred → `TX_VALID=0` immediately; `RESP_CNT` unchanged. After release, a new result 0x0001 sends 0x01, 0x00.
- 256 back-to-back RF responses → `RESP_CNT` wraps to 0; random `TX_READY` backpressure loses and duplicates no bytes (scoreboard).

Source files
------------

// File: rtl/alu_resp_tx.sv
// Response serializer: captures one ALU result or register-file read byte and
// streams it LSB-first as bytes over a valid/ready handshake toward the TX FIFO.
module alu_resp_tx #(
  parameter int OUT_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  OUT_VALID,
  input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
  input  logic                  RF_RD_VALID,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic                  OVERRUN,
  input  logic                  OVR_CLR,
  output logic [7:0]            RESP_CNT
);

  localparam int NUM_BYTES = OUT_WIDTH / 8;
  localparam int CNT_W     = $clog2(NUM_BYTES + 1);

  if ((OUT_WIDTH % 8) != 0 || OUT_WIDTH < 8 || OUT_WIDTH > 64 || DATA_WIDTH != 8) begin : g_bad_param
    $error("alu_resp_tx: OUT_WIDTH must be a multiple of 8 in 8..64 and DATA_WIDTH must be 8");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 r_state, w_state_nxt;
  logic [OUT_WIDTH-1:0]   r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0]       r_bytes_left, w_bytes_left_nxt;
  logic                   r_overrun;
  logic [7:0]             r_resp_cnt;
  logic                   w_last_xfer;
  logic                   w_drop;

  // A strobe is lost if we are already sending, or if both sources fire together in IDLE.
  assign w_drop      = (r_state == SEND) ? (OUT_VALID | RF_RD_VALID) : (OUT_VALID & RF_RD_VALID);
  assign w_last_xfer = (r_state == SEND) && TX_READY && (r_bytes_left == CNT_W'(1));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_bytes_left_nxt = r_bytes_left;
    case (r_state)
      IDLE: begin
        if (OUT_VALID) begin
          w_shreg_nxt      = ALU_OUT;
          w_bytes_left_nxt = CNT_W'(NUM_BYTES);
          w_state_nxt      = SEND;
        end else if (RF_RD_VALID) begin
          w_shreg_nxt      = OUT_WIDTH'(RF_RD_DATA);
          w_bytes_left_nxt = CNT_W'(1);
          w_state_nxt      = SEND;
        end
      end
      SEND: begin
        if (TX_READY) begin
          w_shreg_nxt      = r_shreg >> DATA_WIDTH;
          w_bytes_left_nxt = r_bytes_left - CNT_W'(1);
          if (r_bytes_left == CNT_W'(1)) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_bytes_left <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_bytes_left <= w_bytes_left_nxt;
    end
  end

  // Set beats clear when both land on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_overrun  <= 1'b0;
      r_resp_cnt <= '0;
    end else begin
      if (w_drop)       r_overrun <= 1'b1;
      else if (OVR_CLR) r_overrun <= 1'b0;
      if (w_last_xfer)  r_resp_cnt <= r_resp_cnt + 8'd1;
    end
  end

  assign TX_DATA  = r_shreg[DATA_WIDTH-1:0];
  assign TX_VALID = (r_state == SEND);
  assign BUSY     = (r_state == SEND);
  assign OVERRUN  = r_overrun;
  assign RESP_CNT = r_resp_cnt;

endmodule

// File: tb/tb_alu_resp_tx.sv
// Bench for alu_resp_tx: directed vector table, hand-built corner sequences and
// randomized traffic, all checked against a byte-queue reference model.
module tb_alu_resp_tx;

  localparam int OW = 16;
  localparam int NB = OW / 8;

  logic          CLK;
  logic          RST;
  logic [OW-1:0] ALU_OUT;
  logic          OUT_VALID;
  logic [7:0]    RF_RD_DATA;
  logic          RF_RD_VALID;
  logic [7:0]    TX_DATA;
  logic          TX_VALID;
  logic          TX_READY;
  logic          BUSY;
  logic          OVERRUN;
  logic          OVR_CLR;
  logic [7:0]    RESP_CNT;

  alu_resp_tx #(.OUT_WIDTH(OW), .DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_VALID(RF_RD_VALID), .TX_DATA(TX_DATA),
    .TX_VALID(TX_VALID), .TX_READY(TX_READY), .BUSY(BUSY), .OVERRUN(OVERRUN),
    .OVR_CLR(OVR_CLR), .RESP_CNT(RESP_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes still owed to the FIFO, sticky overrun, response count.
  logic [7:0] m_q[$];
  logic       m_ovr;
  logic [7:0] m_cnt;

  task automatic check_model();
    check("m_tx_valid", 64'(TX_VALID), 64'(m_q.size() != 0));
    check("m_busy",     64'(BUSY),     64'(m_q.size() != 0));
    check("m_overrun",  64'(OVERRUN),  64'(m_ovr));
    check("m_resp_cnt", 64'(RESP_CNT), 64'(m_cnt));
    if (m_q.size() != 0) check("m_tx_data", 64'(TX_DATA), 64'(m_q[0]));
  endtask

  // Entered just after a falling edge; drives one rising edge; returns after the next falling edge.
  task automatic cycle(input logic ov, input logic [OW-1:0] alu, input logic rv,
                       input logic [7:0] rf, input logic rdy, input logic clr);
    logic busy, set_ev;
    check_model();
    OUT_VALID = ov; ALU_OUT = alu; RF_RD_VALID = rv; RF_RD_DATA = rf;
    TX_READY = rdy; OVR_CLR = clr;
    busy   = (m_q.size() != 0);
    set_ev = busy ? (ov | rv) : (ov & rv);
    if (busy) begin
      if (rdy) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_cnt++;
      end
    end else if (ov) begin
      for (int k = 0; k < NB; k++) m_q.push_back(alu[8*k +: 8]);
    end else if (rv) begin
      m_q.push_back(rf);
    end
    if (set_ev) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    @(negedge CLK);
    OUT_VALID = 1'b0; RF_RD_VALID = 1'b0; OVR_CLR = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, 1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic do_reset();
    OUT_VALID = 1'b0; RF_RD_VALID = 1'b0; OVR_CLR = 1'b0;
    RST = 1'b1;
    #1;
    check("rst_tx_valid", 64'(TX_VALID), 64'h0);
    check("rst_busy",     64'(BUSY),     64'h0);
    check("rst_tx_data",  64'(TX_DATA),  64'h0);
    check("rst_overrun",  64'(OVERRUN),  64'h0);
    check("rst_resp_cnt", 64'(RESP_CNT), 64'h0);
    m_q.delete(); m_ovr = 1'b0; m_cnt = 8'd0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  typedef struct {
    logic          ov;
    logic [OW-1:0] alu;
    logic          rv;
    logic [7:0]    rf;
    int            nb;
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic          ovr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int         exp_cnt;
    int         vcount;
    int         n_issued;
    int         n_xfer;
    logic       go;
    logic       rdy;
    logic [7:0] eb;

    vecs[0] = '{1'b1, 16'hA55A, 1'b0, 8'h00, 2, 8'h5A, 8'hA5, 1'b0};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 8'h3C, 1, 8'h3C, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 16'h1234, 1'b1, 8'h77, 2, 8'h34, 8'h12, 1'b1};
    vecs[3] = '{1'b1, 16'hFFFF, 1'b0, 8'h00, 2, 8'hFF, 8'hFF, 1'b0};
    vecs[4] = '{1'b1, 16'h0000, 1'b0, 8'h55, 2, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 16'hDEAD, 1'b1, 8'hFF, 1, 8'hFF, 8'h00, 1'b0};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 8'h00, 1, 8'h00, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 16'h8001, 1'b0, 8'h80, 2, 8'h01, 8'h80, 1'b0};

    RST = 1'b0; ALU_OUT = '0; OUT_VALID = 1'b0; RF_RD_DATA = '0; RF_RD_VALID = 1'b0;
    TX_READY = 1'b0; OVR_CLR = 1'b0;
    #2;
    do_reset();

    // Directed vectors with TX_READY held high.
    exp_cnt = 0;
    foreach (vecs[i]) begin
      cycle(1'b0, '0, 1'b0, 8'h00, 1'b1, 1'b1);
      cycle(vecs[i].ov, vecs[i].alu, vecs[i].rv, vecs[i].rf, 1'b1, 1'b0);
      for (int k = 0; k < vecs[i].nb; k++) begin
        eb = (k == 0) ? vecs[i].b0 : vecs[i].b1;
        check("vec_valid", 64'(TX_VALID), 64'h1);
        check("vec_byte",  64'(TX_DATA),  64'(eb));
        idle(1'b1);
      end
      exp_cnt++;
      check("vec_done_valid", 64'(TX_VALID), 64'h0);
      check("vec_overrun",    64'(OVERRUN),  64'(vecs[i].ovr));
      check("vec_resp_cnt",   64'(RESP_CNT), 64'(exp_cnt));
    end

    // RF byte held stable under 5 cycles of backpressure.
    cycle(1'b0, '0, 1'b1, 8'h3C, 1'b0, 1'b0);
    vcount = 0;
    for (int c = 0; c < 6; c++) begin
      if (TX_VALID) vcount++;
      check("bp_hold_byte", 64'(TX_DATA), 64'h3C);
      idle(c == 5);
    end
    exp_cnt++;
    check("bp_valid_cycles", 64'(vcount),   64'd6);
    check("bp_done_valid",   64'(TX_VALID), 64'h0);
    check("bp_resp_cnt",     64'(RESP_CNT), 64'(exp_cnt));

    // Strobe dropped mid-frame, then on the final-transfer edge; clear; set-vs-clear.
    cycle(1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 16'h1111, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0, 8'h00, 1'b0, 1'b0);
    check("drop_mid_ovr",  64'(OVERRUN), 64'h1);
    check("drop_mid_byte", 64'(TX_DATA), 64'h11);
    cycle(1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_in_send", 64'(OVERRUN), 64'h0);
    idle(1'b1);
    cycle(1'b0, 16'h2222, 1'b1, 8'h99, 1'b1, 1'b0);
    check("drop_last_ovr",  64'(OVERRUN), 64'h1);
    check("drop_last_busy", 64'(BUSY),    64'h0);
    idle(1'b1);
    check("drop_last_nocap", 64'(TX_VALID), 64'h0);
    cycle(1'b0, '0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("ovr_clr", 64'(OVERRUN), 64'h0);
    cycle(1'b1, 16'h3333, 1'b1, 8'h44, 1'b1, 1'b1);
    check("set_beats_clr", 64'(OVERRUN), 64'h1);
    check("set_clr_byte",  64'(TX_DATA), 64'h33);
    idle(1'b1);
    idle(1'b1);

    // Reset in the middle of a frame aborts it.
    cycle(1'b1, 16'hBEEF, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(1'b1);
    check("pre_rst_byte1", 64'(TX_DATA), 64'hBE);
    do_reset();
    cycle(1'b1, 16'h0001, 1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_b0", 64'(TX_DATA), 64'h01);
    idle(1'b1);
    check("post_rst_b1", 64'(TX_DATA), 64'h00);
    idle(1'b1);
    check("post_rst_cnt", 64'(RESP_CNT), 64'h1);

    // 256 back-to-back RF responses with random backpressure: counter wraps.
    do_reset();
    n_issued = 0;
    n_xfer   = 0;
    for (int c = 0; c < 20000 && !(n_issued == 256 && m_q.size() == 0); c++) begin
      go  = (m_q.size() == 0) && (n_issued < 256);
      rdy = ($urandom_range(0, 2) != 0);
      if (go && n_issued == 255) check("wrap_at_255", 64'(RESP_CNT), 64'd255);
      if (go) n_issued++;
      if (TX_VALID && rdy) n_xfer++;
      cycle(1'b0, '0, go, 8'($urandom), rdy, 1'b0);
    end
    check("wrap_finished", 64'(n_issued == 256 && m_q.size() == 0), 64'h1);
    check("wrap_xfers",    64'(n_xfer),   64'd256);
    check("wrap_resp_cnt", 64'(RESP_CNT), 64'h0);

    // Random mixed traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 5) == 0, OW'($urandom), $urandom_range(0, 5) == 0,
            8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
